sliding_averager: RTL and testbench

Parametrised streaming averager for unsigned sample streams, one sample per clock, no backpressure. Supports block mode (one average per N accepted samples) and sliding mode (running average over the last N samples, one result per sample once the window is full). Sits between a sample source and downstream filtering/threshold logic. Selectable round-to-nearest division.

---
 rtl/sliding_averager_if.sv | 32 +++
 rtl/sliding_averager.sv | 119 +++++++++++
 tb/tb_sliding_averager.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sliding_averager_if.sv
// sliding_averager_if
// Groups the sample stream and result stream of sliding_averager.
//   BW      sample/result width
//   inval   sample valid (source -> averager)
//   indata  unsigned sample (source -> averager)
//   mode    0 = block average, 1 = sliding average (source -> averager)
//   clear   synchronous flush of window state (source -> averager)
//   out     registered average result (averager -> consumer)
//   outval  one-cycle pulse per result (averager -> consumer)
//   primed  sliding window holds N samples (averager -> consumer)
// Modports: master = sample source / consumer side, slave = averager.
interface sliding_averager_if #(
    parameter int BW = 8
);
    logic          inval;
    logic [BW-1:0] indata;
    logic          mode;
    logic          clear;
    logic [BW-1:0] out;
    logic          outval;
    logic          primed;

    modport master (
        output inval, indata, mode, clear,
        input  out, outval, primed
    );

    modport slave (
        input  inval, indata, mode, clear,
        output out, outval, primed
    );
endinterface

// File: rtl/sliding_averager.sv
// sliding_averager
// Streaming averager for unsigned samples, one sample per clock, no
// backpressure. Block mode emits one average per N accepted samples;
// sliding mode emits the running average of the last N samples once the
// window has filled.
// Parameters: N (window length, power of 2, >= 2), BW (sample width).
// Ports:
//   clk   clock, all state updates on the rising edge
//   rstn  asynchronous active-low reset
//   bus   sliding_averager_if.slave (inval, indata, mode, clear in;
//         out, outval, primed out)
// Build option: define AVG_ROUND_EN for round-half-up division,
// otherwise the average is truncated.
module sliding_averager #(
    parameter int N  = 8,
    parameter int BW = 8
) (
    input logic              clk,
    input logic              rstn,
    sliding_averager_if.slave bus
);
    localparam int L  = $clog2(N);
    localparam int AW = BW + L;
    localparam logic [L:0]    CNT_FULL = (L+1)'(N);
    localparam logic [L:0]    CNT_LAST = (L+1)'(N - 1);
    localparam logic [AW-1:0] HALF     = AW'(N / 2);

    logic [BW-1:0] sample_buf [N];
    logic [L-1:0]  wptr;
    logic [L:0]    cnt;
    logic [AW-1:0] acc;
    logic          mode_q;

    logic          flush;
    logic          accept;
    logic [AW-1:0] in_ext;
    logic [AW-1:0] old_ext;
    logic [AW-1:0] block_sum;
    logic [AW-1:0] slide_sum;
    logic [L:0]    cnt_inc;

    // Division by N is a shift; the rounding bias cannot overflow AW bits
    // because the largest sum is N*(2^BW-1).
    function automatic logic [BW-1:0] div_sum(input logic [AW-1:0] s);
        logic [AW-1:0] t;
`ifdef AVG_ROUND_EN
        t = s + HALF;
`else
        t = s;
`endif
        return t[AW-1:L];
    endfunction

    // A mode change flushes exactly like clear, and any sample presented in
    // a flushing cycle is dropped.
    assign flush     = bus.clear || (bus.mode != mode_q);
    assign accept    = bus.inval && !flush;
    assign in_ext    = {{L{1'b0}}, bus.indata};
    // Only a full window has a sample to retire; buffer contents beyond cnt
    // are stale and must not be subtracted.
    assign old_ext   = (cnt == CNT_FULL) ? {{L{1'b0}}, sample_buf[wptr]} : '0;
    assign block_sum = acc + in_ext;
    assign slide_sum = acc + in_ext - old_ext;
    assign cnt_inc   = (cnt == CNT_FULL) ? CNT_FULL : cnt + (L+1)'(1);

    // The sample buffer needs no reset: entries are only read once cnt says
    // they hold valid samples.
    always_ff @(posedge clk) begin
        if (accept && mode_q) begin
            sample_buf[wptr] <= bus.indata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc        <= '0;
            cnt        <= '0;
            wptr       <= '0;
            mode_q     <= 1'b0;
            bus.out    <= '0;
            bus.outval <= 1'b0;
            bus.primed <= 1'b0;
        end else if (flush) begin
            acc        <= '0;
            cnt        <= '0;
            wptr       <= '0;
            mode_q     <= bus.mode;
            bus.outval <= 1'b0;
            bus.primed <= 1'b0;
        end else if (accept) begin
            if (!mode_q) begin
                if (cnt == CNT_LAST) begin
                    bus.out    <= div_sum(block_sum);
                    bus.outval <= 1'b1;
                    acc        <= '0;
                    cnt        <= '0;
                end else begin
                    acc        <= block_sum;
                    cnt        <= cnt + (L+1)'(1);
                    bus.outval <= 1'b0;
                end
            end else begin
                acc  <= slide_sum;
                cnt  <= cnt_inc;
                wptr <= wptr + L'(1);
                // cnt+1 >= N, i.e. this sample fills or slides a full window.
                if (cnt >= CNT_LAST) begin
                    bus.out    <= div_sum(slide_sum);
                    bus.outval <= 1'b1;
                    bus.primed <= 1'b1;
                end else begin
                    bus.outval <= 1'b0;
                end
            end
        end else begin
            bus.outval <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sliding_averager.sv
// tb_sliding_averager
// Self-checking bench for sliding_averager with N=4, BW=4. A reference
// model keeps the literal window of accepted samples and pushes each
// expected average to a queue; DUT results are popped and compared.
// Works with or without AVG_ROUND_EN defined.
module tb_sliding_averager;
    localparam int N  = 4;
    localparam int BW = 4;
    localparam int L  = 2;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    sliding_averager_if #(.BW(BW)) bus ();

    sliding_averager #(.N(N), .BW(BW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int   checks = 0;
    int   passed = 0;
    int   exp_q[$];
    int   win[$];
    logic m_mode_q = 1'b0;
    logic m_outval = 1'b0;
    logic m_primed = 1'b0;

    function automatic int divide(input int s);
`ifdef AVG_ROUND_EN
        return (s + N / 2) >> L;
`else
        return s >> L;
`endif
    endfunction

    // Reference behaviour: the window is kept as a list of samples and
    // summed from scratch every time a result is due.
    function automatic void model_step(input logic v, input int d, input logic m, input logic c);
        int sum;
        m_outval = 1'b0;
        if (c || (m !== m_mode_q)) begin
            m_mode_q = m;
            win.delete();
            m_primed = 1'b0;
        end else if (v) begin
            win.push_back(d);
            if (m_mode_q && win.size() > N) void'(win.pop_front());
            if (win.size() == N) begin
                sum = 0;
                foreach (win[i]) sum += win[i];
                exp_q.push_back(divide(sum));
                m_outval = 1'b1;
                if (m_mode_q) m_primed = 1'b1;
                else win.delete();
            end
        end
    endfunction

    function automatic void model_reset();
        m_mode_q = 1'b0;
        m_outval = 1'b0;
        m_primed = 1'b0;
        win.delete();
        exp_q.delete();
    endfunction

    // Drives one cycle of stimulus, advances the model at the edge, and
    // returns 1 time unit after the edge so outputs are settled.
    task automatic apply(input logic v, input int d, input logic m, input logic c);
        bus.inval  = v;
        bus.indata = d[BW-1:0];
        bus.mode   = m;
        bus.clear  = c;
        @(posedge clk);
        model_step(v, d, m, c);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.out !== 4'd0) $display("[TB] FAIL reset_out: got %0d expected 0", bus.out);
        else passed++;
        checks++;
        if (bus.outval !== 1'b0) $display("[TB] FAIL reset_outval: got %b expected 0", bus.outval);
        else passed++;
        checks++;
        if (bus.primed !== 1'b0) $display("[TB] FAIL reset_primed: got %b expected 0", bus.primed);
        else passed++;
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
    endtask

    task automatic test_block_basic();
        int d[4] = '{1, 2, 3, 4};
        int e;
        for (int i = 0; i < 6; i++) begin
            apply(i < 4, (i < 4) ? d[i] : 0, 1'b0, 1'b0);
            checks++;
            if (bus.outval !== m_outval) $display("[TB] FAIL block_basic_outval[%0d]: got %b expected %b", i, bus.outval, m_outval);
            else passed++;
            if (bus.outval === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) $display("[TB] FAIL block_basic_extra: got out %0d expected no result", bus.out);
                else begin
                    e = exp_q.pop_front();
                    if (bus.out !== e[BW-1:0]) $display("[TB] FAIL block_basic_out: got %0d expected %0d", bus.out, e);
                    else passed++;
                end
            end
        end
        e = 2;
`ifdef AVG_ROUND_EN
        e = 3;
`endif
        checks++;
        if (bus.out !== e[BW-1:0]) $display("[TB] FAIL block_basic_hold: got %0d expected %0d", bus.out, e);
        else passed++;
    endtask

    task automatic test_block_gaps();
        int e;
        for (int i = 0; i < 12; i++) begin
            apply((i % 3) == 0, 15, 1'b0, 1'b0);
            checks++;
            if (bus.outval !== m_outval) $display("[TB] FAIL block_gaps_outval[%0d]: got %b expected %b", i, bus.outval, m_outval);
            else passed++;
            if (bus.outval === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) $display("[TB] FAIL block_gaps_extra: got out %0d expected no result", bus.out);
                else begin
                    e = exp_q.pop_front();
                    if (bus.out !== e[BW-1:0]) $display("[TB] FAIL block_gaps_out: got %0d expected %0d", bus.out, e);
                    else passed++;
                end
            end
        end
        checks++;
        if (bus.out !== 4'd15) $display("[TB] FAIL block_gaps_hold: got %0d expected 15", bus.out);
        else passed++;
    endtask

    task automatic test_sliding();
        int d[6] = '{0, 4, 8, 12, 0, 8};
        logic v[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        int e;
        for (int i = 0; i < 6; i++) begin
            apply(v[i], d[i], 1'b1, 1'b0);
            checks++;
            if (bus.outval !== m_outval) $display("[TB] FAIL sliding_outval[%0d]: got %b expected %b", i, bus.outval, m_outval);
            else passed++;
            checks++;
            if (bus.primed !== m_primed) $display("[TB] FAIL sliding_primed[%0d]: got %b expected %b", i, bus.primed, m_primed);
            else passed++;
            if (bus.outval === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) $display("[TB] FAIL sliding_extra: got out %0d expected no result", bus.out);
                else begin
                    e = exp_q.pop_front();
                    if (bus.out !== e[BW-1:0]) $display("[TB] FAIL sliding_out: got %0d expected %0d", bus.out, e);
                    else passed++;
                end
            end
        end
        checks++;
        if (bus.out !== 4'd7) $display("[TB] FAIL sliding_last: got %0d expected 7", bus.out);
        else passed++;
    endtask

    task automatic test_clear();
        int  d[7] = '{9, 9, 9, 1, 1, 1, 1};
        logic c[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        int e;
        apply(1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            apply(i < 7, (i < 7) ? d[i] : 0, 1'b0, (i < 7) ? c[i] : 1'b0);
            checks++;
            if (bus.outval !== m_outval) $display("[TB] FAIL clear_outval[%0d]: got %b expected %b", i, bus.outval, m_outval);
            else passed++;
            if (bus.outval === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) $display("[TB] FAIL clear_extra: got out %0d expected no result", bus.out);
                else begin
                    e = exp_q.pop_front();
                    if (bus.out !== e[BW-1:0]) $display("[TB] FAIL clear_out: got %0d expected %0d", bus.out, e);
                    else passed++;
                end
            end
        end
        checks++;
        if (bus.out !== 4'd1) $display("[TB] FAIL clear_result: got %0d expected 1", bus.out);
        else passed++;
    endtask

    task automatic test_mode_change();
        int  d[10] = '{0, 4, 8, 12, 0, 9, 2, 2, 2, 2};
        logic v[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic m[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        int e;
        for (int i = 0; i < 10; i++) begin
            apply(v[i], d[i], m[i], 1'b0);
            checks++;
            if (bus.outval !== m_outval) $display("[TB] FAIL mode_outval[%0d]: got %b expected %b", i, bus.outval, m_outval);
            else passed++;
            checks++;
            if (bus.primed !== m_primed) $display("[TB] FAIL mode_primed[%0d]: got %b expected %b", i, bus.primed, m_primed);
            else passed++;
            if (bus.outval === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) $display("[TB] FAIL mode_extra: got out %0d expected no result", bus.out);
                else begin
                    e = exp_q.pop_front();
                    if (bus.out !== e[BW-1:0]) $display("[TB] FAIL mode_out: got %0d expected %0d", bus.out, e);
                    else passed++;
                end
            end
        end
        checks++;
        if (bus.out !== 4'd2) $display("[TB] FAIL mode_result: got %0d expected 2", bus.out);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int e;
        int d;
        int results;
        results = 0;
        apply(1'b0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 24; i++) begin
            d = int'($urandom_range(0, 15));
            apply(1'b1, d, 1'b1, 1'b0);
            checks++;
            if (bus.outval !== m_outval) $display("[TB] FAIL b2b_outval[%0d]: got %b expected %b", i, bus.outval, m_outval);
            else passed++;
            if (bus.outval === 1'b1) begin
                results++;
                checks++;
                if (exp_q.size() == 0) $display("[TB] FAIL b2b_extra: got out %0d expected no result", bus.out);
                else begin
                    e = exp_q.pop_front();
                    if (bus.out !== e[BW-1:0]) $display("[TB] FAIL b2b_out: got %0d expected %0d", bus.out, e);
                    else passed++;
                end
            end
        end
        checks++;
        if (results !== 21) $display("[TB] FAIL b2b_count: got %0d results expected 21", results);
        else passed++;
    endtask

    task automatic test_async_reset();
        int e;
        apply(1'b1, 7, 1'b1, 1'b0);
        apply(1'b1, 3, 1'b1, 1'b0);
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus.out !== 4'd0) $display("[TB] FAIL areset_out: got %0d expected 0", bus.out);
        else passed++;
        checks++;
        if (bus.outval !== 1'b0) $display("[TB] FAIL areset_outval: got %b expected 0", bus.outval);
        else passed++;
        checks++;
        if (bus.primed !== 1'b0) $display("[TB] FAIL areset_primed: got %b expected 0", bus.primed);
        else passed++;
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            apply(i < 5, 3 * i + 3, 1'b1, 1'b0);
            checks++;
            if (bus.outval !== m_outval) $display("[TB] FAIL areset_after_outval[%0d]: got %b expected %b", i, bus.outval, m_outval);
            else passed++;
            checks++;
            if (bus.primed !== m_primed) $display("[TB] FAIL areset_after_primed[%0d]: got %b expected %b", i, bus.primed, m_primed);
            else passed++;
            if (bus.outval === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) $display("[TB] FAIL areset_extra: got out %0d expected no result", bus.out);
                else begin
                    e = exp_q.pop_front();
                    if (bus.out !== e[BW-1:0]) $display("[TB] FAIL areset_after_out: got %0d expected %0d", bus.out, e);
                    else passed++;
                end
            end
        end
    endtask

    initial begin
        bus.inval  = 1'b0;
        bus.indata = '0;
        bus.mode   = 1'b0;
        bus.clear  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_block_basic();
        test_block_gaps();
        test_sliding();
        test_mode_change();
        test_clear();
        test_back_to_back();
        test_async_reset();
        checks++;
        if (exp_q.size() != 0) $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
